// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the snooping-bus arbiter.
package bus_arbiter_pkg;

  localparam int NUM_CACHES = 3;

  localparam logic [1:0] CACHE0 = 2'b00;
  localparam logic [1:0] CACHE1 = 2'b01;
  localparam logic [1:0] CACHE2 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_SNOOP = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Cache ID that follows id in round-robin order (2 wraps to 0).
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == CACHE2) ? CACHE0 : id + 2'd1;
  endfunction

  // Isolate the lowest set bit of a cache vector (0 if none set).
  function automatic logic [NUM_CACHES-1:0] low_bit(input logic [NUM_CACHES-1:0] v);
    return v & (~v + 3'd1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Handshake and strobe bundle between the arbiter and the three caches.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [NUM_CACHES-1:0] req;
  logic [NUM_CACHES-1:0] msg_valid;
  logic [NUM_CACHES-1:0] wb_req;
  logic [NUM_CACHES-1:0] grant;
  logic                  snoop_en;
  logic [NUM_CACHES-1:0] wb_grant;
  logic                  busy;
  logic                  abort;

  // Arbiter side.
  modport master (
    input  req, msg_valid, wb_req,
    output grant, snoop_en, wb_grant, busy, abort
  );

  // Cache side.
  modport slave (
    output req, msg_valid, wb_req,
    input  grant, snoop_en, wb_grant, busy, abort
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder over the three cache requests.
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_CACHES-1:0] req,
  input  logic [1:0]            ptr,
  output logic [NUM_CACHES-1:0] win,
  output logic [1:0]            win_idx
);

  // Scan from ptr upward with wrap; first requester found wins.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    win     = '0;
    win_idx = CACHE0;
    found   = 1'b0;
    idx     = (ptr > CACHE2) ? CACHE0 : ptr;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (!found && req[idx]) begin
        found      = 1'b1;
        win[idx]   = 1'b1;
        win_idx    = idx;
      end
      idx = next_id(idx);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant, then ADDR -> SNOOP -> (WB) -> DONE.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int SNOOP_CYCLES = 2,
  parameter int TIMEOUT      = 8
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  state_t                state, state_n;
  logic [1:0]            ptr, ptr_n;
  logic [1:0]            owner, owner_n;
  logic [3:0]            cnt, cnt_n;
  logic [NUM_CACHES-1:0] wb_pend, wb_pend_n;
  logic [NUM_CACHES-1:0] grant_q, grant_n;
  logic [NUM_CACHES-1:0] wb_grant_q, wb_grant_n;
  logic                  snoop_q, snoop_n;
  logic                  busy_q, busy_n;
  logic                  abort_q, abort_n;

  logic [NUM_CACHES-1:0] win;
  logic [1:0]            win_idx;
  logic [NUM_CACHES-1:0] pend_acc;
  logic [NUM_CACHES-1:0] pend_sel;
  logic [NUM_CACHES-1:0] wb_sel;

  rr_pick u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  // Non-owner write-back requests folded into the pending set; the owner's
  // own bit is masked since it is the one driving the bus.
  assign pend_acc = wb_pend | (bus.wb_req & ~grant_q);
  assign pend_sel = low_bit(pend_acc);
  assign wb_sel   = low_bit(wb_pend);

  // Next-state and next-output logic; every output is computed here and
  // registered below so the caches see glitch-free strobes.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    owner_n    = owner;
    cnt_n      = cnt;
    wb_pend_n  = wb_pend;
    grant_n    = grant_q;
    wb_grant_n = '0;
    snoop_n    = 1'b0;
    abort_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        grant_n = '0;
        if (|bus.req) begin
          state_n = S_ADDR;
          grant_n = win;
          owner_n = win_idx;
          cnt_n   = '0;
        end
      end
      S_ADDR: begin
        if (bus.msg_valid[owner]) begin
          state_n = S_SNOOP;
          cnt_n   = '0;
          snoop_n = 1'b1;
        end else if (cnt == 4'(TIMEOUT - 1)) begin
          // Owner never produced its message: drop it, move the pointer on.
          state_n = S_IDLE;
          grant_n = '0;
          cnt_n   = '0;
          abort_n = 1'b1;
          ptr_n   = next_id(owner);
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      S_SNOOP: begin
        wb_pend_n = pend_acc;
        if (cnt == 4'(SNOOP_CYCLES - 1)) begin
          cnt_n = '0;
          if (|pend_acc) begin
            // First write-back strobe issues on the cycle WB is entered.
            state_n    = S_WB;
            wb_grant_n = pend_sel;
            wb_pend_n  = pend_acc & ~pend_sel;
          end else begin
            state_n = S_DONE;
            grant_n = '0;
          end
        end else begin
          cnt_n   = cnt + 4'd1;
          snoop_n = 1'b1;
        end
      end
      S_WB: begin
        if (|wb_pend) begin
          wb_grant_n = wb_sel;
          wb_pend_n  = wb_pend & ~wb_sel;
        end else begin
          state_n = S_DONE;
          grant_n = '0;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        ptr_n   = next_id(owner);
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= CACHE0;
      owner      <= CACHE0;
      cnt        <= '0;
      wb_pend    <= '0;
      grant_q    <= '0;
      wb_grant_q <= '0;
      snoop_q    <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      owner      <= owner_n;
      cnt        <= cnt_n;
      wb_pend    <= wb_pend_n;
      grant_q    <= grant_n;
      wb_grant_q <= wb_grant_n;
      snoop_q    <= snoop_n;
      busy_q     <= busy_n;
      abort_q    <= abort_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.wb_grant = wb_grant_q;
  assign bus.snoop_en = snoop_q;
  assign bus.busy     = busy_q;
  assign bus.abort    = abort_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter; output vector is {busy,abort,snoop_en,wb_grant,grant}.
module tb_bus_arbiter;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_pass;

  bus_arbiter_if bus ();

  bus_arbiter #(.SNOOP_CYCLES(2), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [8:0] ev(input logic b, input logic a, input logic s,
                                    input logic [2:0] wg, input logic [2:0] g);
    return {b, a, s, wg, g};
  endfunction

  function automatic logic [8:0] obs();
    return {bus.busy, bus.abort, bus.snoop_en, bus.wb_grant, bus.grant};
  endfunction

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b exp %b", tag, got, exp);
  endtask

  // Advance one edge; inputs set after this are sampled on the next edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [2:0] g_seq [4];

  initial begin
    n_chk = 0;
    n_pass = 0;
    g_seq = '{3'b010, 3'b100, 3'b001, 3'b010};
    reset = 1'b1;
    bus.req = '0;
    bus.msg_valid = '0;
    bus.wb_req = '0;
    step();
    step();
    chk("reset", obs(), ev(0, 0, 0, 3'b000, 3'b000));
    reset = 1'b0;

    // Single owner-0 transaction, message ready in the first ADDR cycle.
    bus.req = 3'b001;
    step(); chk("t1_addr", obs(), ev(1, 0, 0, 3'b000, 3'b001));
    bus.req = '0; bus.msg_valid = 3'b001;
    step(); chk("t1_snoop0", obs(), ev(1, 0, 1, 3'b000, 3'b001));
    bus.msg_valid = '0;
    step(); chk("t1_snoop1", obs(), ev(1, 0, 1, 3'b000, 3'b001));
    step(); chk("t1_done", obs(), ev(1, 0, 0, 3'b000, 3'b000));
    step(); chk("t1_idle", obs(), ev(0, 0, 0, 3'b000, 3'b000));

    // All three requesting continuously; pointer is now 1.
    bus.req = 3'b111; bus.msg_valid = 3'b111;
    for (int t = 0; t < 4; t++) begin
      step(); chk($sformatf("t2_addr%0d", t), obs(), ev(1, 0, 0, 3'b000, g_seq[t]));
      step(); chk($sformatf("t2_sn0_%0d", t), obs(), ev(1, 0, 1, 3'b000, g_seq[t]));
      step(); chk($sformatf("t2_sn1_%0d", t), obs(), ev(1, 0, 1, 3'b000, g_seq[t]));
      step(); chk($sformatf("t2_done%0d", t), obs(), ev(1, 0, 0, 3'b000, 3'b000));
      step(); chk($sformatf("t2_idle%0d", t), obs(), ev(0, 0, 0, 3'b000, 3'b000));
    end

    // Owner 1 with write-backs from 0 and 2; owner's own wb_req is masked.
    bus.req = 3'b010; bus.msg_valid = '0;
    step(); chk("t3_addr", obs(), ev(1, 0, 0, 3'b000, 3'b010));
    bus.req = '0; bus.msg_valid = 3'b010; bus.wb_req = 3'b111;
    step(); chk("t3_snoop0", obs(), ev(1, 0, 1, 3'b000, 3'b010));
    bus.msg_valid = '0;
    step(); chk("t3_snoop1", obs(), ev(1, 0, 1, 3'b000, 3'b010));
    bus.wb_req = '0;
    step(); chk("t3_wb0", obs(), ev(1, 0, 0, 3'b001, 3'b010));
    step(); chk("t3_wb2", obs(), ev(1, 0, 0, 3'b100, 3'b010));
    step(); chk("t3_done", obs(), ev(1, 0, 0, 3'b000, 3'b000));
    step(); chk("t3_idle", obs(), ev(0, 0, 0, 3'b000, 3'b000));

    // Owner 2 times out; non-owner msg_valid must not advance the phase.
    bus.req = 3'b100;
    step(); chk("t4_addr0", obs(), ev(1, 0, 0, 3'b000, 3'b100));
    bus.req = '0; bus.msg_valid = 3'b011;
    for (int c = 1; c < 8; c++) begin
      step(); chk($sformatf("t4_addr%0d", c), obs(), ev(1, 0, 0, 3'b000, 3'b100));
    end
    step(); chk("t4_abort", obs(), ev(0, 1, 0, 3'b000, 3'b000));
    bus.msg_valid = '0; bus.req = 3'b111;
    step(); chk("t4_next0", obs(), ev(1, 0, 0, 3'b000, 3'b001));

    // Owner 0 with write-backs from 1 and 2; reset lands in the first WB cycle.
    bus.req = '0; bus.msg_valid = 3'b001;
    step(); chk("t5_snoop0", obs(), ev(1, 0, 1, 3'b000, 3'b001));
    bus.msg_valid = '0; bus.wb_req = 3'b110;
    step(); chk("t5_snoop1", obs(), ev(1, 0, 1, 3'b000, 3'b001));
    bus.wb_req = '0;
    step(); chk("t5_wb1", obs(), ev(1, 0, 0, 3'b010, 3'b001));
    reset = 1'b1;
    step(); chk("t5_reset", obs(), ev(0, 0, 0, 3'b000, 3'b000));
    reset = 1'b0; bus.req = 3'b010;
    step(); chk("t5_regrant", obs(), ev(1, 0, 0, 3'b000, 3'b010));
    bus.req = '0; bus.msg_valid = 3'b010;
    step(); chk("t5_snoop0b", obs(), ev(1, 0, 1, 3'b000, 3'b010));
    bus.msg_valid = '0;
    step(); chk("t5_snoop1b", obs(), ev(1, 0, 1, 3'b000, 3'b010));
    step(); chk("t5_done_nowb", obs(), ev(1, 0, 0, 3'b000, 3'b000));
    step(); chk("t5_idle", obs(), ev(0, 0, 0, 3'b000, 3'b000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
